// File: rtl/s_arb_pkg.sv
// rtl/s_arb_pkg.sv - shared types, defaults and helpers for the S-memory arbiter
package s_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_AW         = 8;
    localparam int DEF_DW         = 8;

    // Never returns less than 1 so a single requester still gets a legal index field.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/s_arb_rdpipe.sv
// rtl/s_arb_rdpipe.sv - read tag pipeline returning a one-hot rvalid RD_LATENCY cycles after issue
import s_arb_pkg::*;

module s_arb_rdpipe #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int OW         = clog2(DEF_NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_i,
    input  logic [OW-1:0]      owner_i,
    output logic [NUM_REQ-1:0] rvalid_o
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [OW-1:0]         tag_q [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= issue_i;
            tag_q[0]   <= owner_i;
            for (int k = 1; k < RD_LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_o[i] = valid_q[RD_LATENCY-1] && (tag_q[RD_LATENCY-1] == OW'(i));
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// rtl/s_mem_arbiter.sv - lock-based S-memory port arbiter; S_ARB_ROUND_ROBIN_EN selects round-robin
import s_arb_pkg::*;

module s_mem_arbiter #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    acc,
    input  logic [NUM_REQ-1:0]    wren,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_wren,
    input  logic [DW-1:0]         mem_q
);

    localparam int OW = clog2(NUM_REQ);
    localparam int CW = 3;

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] winner;

    logic          own_req, own_acc, own_wren;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          granted, rd_issue;

    always_comb begin
        own_req   = 1'b0;
        own_acc   = 1'b0;
        own_wren  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_req   = req[i];
                own_acc   = acc[i];
                own_wren  = wren[i];
                own_addr  = addr[i*AW +: AW];
                own_wdata = wdata[i*DW +: DW];
            end
        end
    end

`ifdef S_ARB_ROUND_ROBIN_EN
    logic [OW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    // Search begins one past the last owner so a continuously requesting client cannot starve others.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && |req) begin
            ptr_d = (winner == OW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = OW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = winner;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(RD_LATENCY - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // The RAM port is only driven during GRANT; DRAIN keeps it quiet while reads finish.
    assign granted   = (state_q == GRANT);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = granted ? own_addr : '0;
    assign mem_wdata = granted ? own_wdata : '0;
    assign mem_wren  = granted & own_acc & own_wren;
    assign rd_issue  = granted & own_acc & ~own_wren;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = granted && (owner_q == OW'(i));
        end
    end

    s_arb_rdpipe #(
        .NUM_REQ    (NUM_REQ),
        .RD_LATENCY (RD_LATENCY),
        .OW         (OW)
    ) u_rdpipe (
        .clk      (clk),
        .reset    (reset),
        .issue_i  (rd_issue),
        .owner_i  (owner_q),
        .rvalid_o (rvalid)
    );

    assign rdata = (|rvalid) ? mem_q : '0;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb/tb_s_mem_arbiter.sv - directed self-checking bench for s_mem_arbiter with a 2-cycle RAM model
module tb_s_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0, acc = '0, wren = '0;
    logic [23:0] addr = '0, wdata = '0;
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata, mem_addr, mem_wdata, mem_q;
    logic        busy, mem_wren;

    logic [7:0]  ram [256];
    logic [7:0]  q1;

    int vectors = 0;
    int miscompares = 0;
    int wcnt, bad, seen;

`ifdef S_ARB_ROUND_ROBIN_EN
    localparam logic [2:0] EXP_CONT = 3'b100;
`else
    localparam logic [2:0] EXP_CONT = 3'b001;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        q1    <= ram[mem_addr];
        mem_q <= q1;
    end

    s_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .acc       (acc),
        .wren      (wren),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);

        @(negedge clk);
        reset = 1'b1;
        req = 3'b001;
        #1;
        chk("grant_latency_gnt", gnt, 0);
        chk("grant_latency_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("gnt_owner0", gnt, 3'b001);
        chk("busy_owner0", busy, 1);

        wcnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) @(negedge clk);
            acc = 3'b001;
            wren = 3'b001;
            addr[7:0] = 8'(i);
            wdata[7:0] = 8'(i);
            #1;
            if (mem_wren === 1'b1 && mem_addr === 8'(i) && mem_wdata === 8'(i)) wcnt++;
        end
        chk("init_write_cycles", wcnt, 256);

        @(negedge clk);
        acc = '0;
        wren = '0;
        req = '0;
        #1;
        chk("drop_cycle_gnt", gnt, 3'b001);
        chk("drop_cycle_wren", mem_wren, 0);
        @(negedge clk);
        #1;
        chk("drain1_gnt", gnt, 0);
        chk("drain1_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("drain2_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== 8'(i)) bad++;
        end
        chk("ram_identity", bad, 0);

        req = 3'b110;
        @(negedge clk);
        #1;
        chk("simul_req_gnt", gnt, 3'b010);
        acc = 3'b010;
        wren = 3'b000;
        addr[15:8] = 8'h05;
        #1;
        chk("read_mem_addr", mem_addr, 8'h05);
        chk("read_mem_wren", mem_wren, 0);
        @(negedge clk);
        acc = '0;
        req = 3'b101;
        #1;
        chk("rd_t1_gnt", gnt, 3'b010);
        chk("rd_t1_rvalid", rvalid, 0);
        @(negedge clk);
        #1;
        chk("rd_t2_gnt", gnt, 0);
        chk("rd_t2_busy", busy, 1);
        chk("rd_t2_rvalid", rvalid, 3'b010);
        chk("rd_t2_rdata", rdata, 8'h05);
        @(negedge clk);
        #1;
        chk("rd_t3_rvalid", rvalid, 0);
        chk("rd_t3_gnt_wait", gnt, 0);
        chk("rd_t3_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("rd_t4_busy", busy, 0);
        chk("rd_t4_gnt", gnt, 0);
        @(negedge clk);
        #1;
        chk("contend_gnt", gnt, EXP_CONT);
        req = '0;
        @(negedge clk);
        #1;
        chk("short_grant_gnt", gnt, 0);
        chk("short_grant_busy", busy, 1);
        chk("short_grant_rvalid", rvalid, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("short_grant_idle", busy, 0);

        req = 3'b001;
        @(negedge clk);
        #1;
        chk("own0_gnt", gnt, 3'b001);
        acc = 3'b101;
        wren = 3'b101;
        addr[23:16] = 8'h10;
        wdata[23:16] = 8'hAA;
        addr[7:0] = 8'h20;
        wdata[7:0] = 8'h20;
        #1;
        chk("owner_only_wren", mem_wren, 1);
        chk("owner_only_addr", mem_addr, 8'h20);
        chk("owner_only_wdata", mem_wdata, 8'h20);
        @(negedge clk);
        acc = 3'b100;
        wren = 3'b100;
        #1;
        chk("nonowner_wren", mem_wren, 0);
        req = '0;
        @(negedge clk);
        acc = '0;
        wren = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("nonowner_ram16", ram[16], 8'h10);
        chk("owner_ram32", ram[32], 8'h20);
        chk("own0_idle", busy, 0);

        req = 3'b010;
        @(negedge clk);
        #1;
        chk("rst_burst_gnt", gnt, 3'b010);
        acc = 3'b010;
        wren = 3'b000;
        addr[15:8] = 8'h05;
        @(negedge clk);
        acc = '0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rdata", rdata, 0);
        reset = 1'b1;
        req = '0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (rvalid !== 3'b000) seen++;
        end
        chk("no_late_rvalid", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
